// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for the 5-stage RV32 pipeline. Produces the
// hold/bubble/flush/freeze controls for the PC and the IF/ID, ID/EX, EX/MEM
// and MEM/WB registers from three hazard sources:
//   * load-use      : instruction in ID reads the rd of a load sitting in EX
//   * redirect      : taken branch / jal / jalr resolved in EX
//   * memory wait   : data memory has not acknowledged the MEM-stage access
// A two-state FSM (RUN / MEMWAIT) tracks multi-cycle memory waits and aborts
// them after MEM_TIMEOUT frozen cycles with a one-cycle mem_err pulse.
// Two saturating counters report stall cycles and redirect flushes.
//
// Parameters
//   MEM_TIMEOUT  frozen cycles allowed in a memory wait before abort (2..255)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   id_rs1/id_rs2            ID-stage source registers
//   id_use_rs1/id_use_rs2    ID-stage instruction really reads rs1/rs2
//   ex_rd, ex_memread        destination / MemRead of the ID/EX register
//   redirect                 control transfer resolved in EX this cycle
//   mem_req, mem_ack         data-memory request / completion
//   pc_stall, ifid_stall     hold PC / IF/ID
//   idex_bubble              load ID/EX with side-effect controls cleared
//   ifid_flush, idex_flush   clear IF/ID / ID/EX to a NOP
//   pipe_freeze              hold every register; MEM/WB loads a bubble
//   mem_err                  one-cycle pulse on memory-wait timeout
//   stall_cnt, flush_cnt     saturating performance counters
//
// All control outputs are combinational from the current inputs and the
// registered state, so they are valid before the edge that must honour them.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    // Bundle of every pipeline control produced in a cycle.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic idex_bubble;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_freeze;
        logic mem_err;
    } ctrl_t;

    localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state, state_nx;
    logic [7:0] wcnt, wcnt_nx;

    logic  lu;          // load-use hazard on the instruction in ID
    logic  mw;          // MEM-stage access still outstanding
    logic  hold_wait;   // MEMWAIT continues another frozen cycle
    logic  timeout;     // MEMWAIT gives up this cycle
    logic  frozen;      // whole pipeline holds this cycle
    ctrl_t ctrl;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    // x0 is never a real dependency, so ex_rd==0 is excluded.
    always_comb begin
        lu = ex_memread && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) ||
              (id_use_rs2 && (ex_rd == id_rs2)));
    end

    assign mw = mem_req && !mem_ack;

    // Inside MEMWAIT only the acknowledge matters: the MEM instruction is
    // frozen in place, so mem_req is implied.
    assign hold_wait = (state == MEMWAIT) && !mem_ack && (wcnt < TMO);
    assign timeout   = (state == MEMWAIT) && !mem_ack && !(wcnt < TMO);

    assign frozen = (state == RUN) ? mw : hold_wait;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    // wcnt counts frozen cycles of the current wait, the entry cycle being 1,
    // so a wait that never acks freezes for exactly MEM_TIMEOUT cycles.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            RUN: begin
                if (mw) begin
                    state_nx = MEMWAIT;
                    wcnt_nx  = 8'd1;
                end
            end
            MEMWAIT: begin
                if (hold_wait) begin
                    wcnt_nx = wcnt + 8'd1;
                end else begin
                    // ack or timeout: this is the release cycle
                    state_nx = RUN;
                    wcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = RUN;
                wcnt_nx  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    // Priority: freeze > redirect > load-use. A release cycle out of MEMWAIT
    // (ack or timeout) falls through to the normal redirect / load-use
    // decision so no redirect is lost while the pipeline was held.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl = '0;
        end else if (frozen) begin
            ctrl.pipe_freeze = 1'b1;
            ctrl.pc_stall    = 1'b1;
            ctrl.ifid_stall  = 1'b1;
        end else begin
            ctrl.mem_err = timeout;
            if (redirect) begin
                // the instruction in ID is squashed, so its load-use
                // dependency is irrelevant
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (lu) begin
                // one bubble is enough: next cycle the bubble sits in ID/EX
                // and lu drops by itself
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_bubble = 1'b1;
            end
        end
    end

    assign pc_stall    = ctrl.pc_stall;
    assign ifid_stall  = ctrl.ifid_stall;
    assign idex_bubble = ctrl.idex_bubble;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign pipe_freeze = ctrl.pipe_freeze;
    assign mem_err     = ctrl.mem_err;

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl.pc_stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (ctrl.ifid_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 core. Drives the stall/bubble, flush and freeze inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Inputs are the ID-stage source operands, the ID/EX destination and control bits, the EX-stage redirect, and the data-memory request/acknowledge handshake. A small FSM covers multi-cycle memory waits with a timeout, and saturating counters report stall and flush activity.

## Interface
- MEM_TIMEOUT, default 16: max cycles spent in MEMWAIT before abort; legal range 2..255.
- CNT_W, default 32: width of the performance counters.

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- id_rs1, id_rs2  input  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  input  1 each  the instruction in ID actually reads rs1/rs2
- ex_rd  input  5  rd_out of ID/EX
- ex_memread  input  1  MemRead_out of ID/EX
- redirect  input  1  branch taken / jal / jalr resolved in EX this cycle
- mem_req  input  1  the instruction in MEM accesses data memory
- mem_ack  input  1  data memory completes the access this cycle
- pc_stall  output  1  PC holds its value
- ifid_stall  output  1  IF/ID holds its value
- idex_bubble  output  1  drives the ID/EX stall input; ID/EX loads with MemRead/MemWrite/RegWrite forced to 0
- ifid_flush, idex_flush  output  1 each  clear the register to a NOP
- pipe_freeze  output  1  every pipeline register and the PC hold; MEM/WB loads a bubble
- mem_err  output  1  one-cycle pulse on memory timeout
- stall_cnt  output  CNT_W  cycles with pc_stall=1, saturating
- flush_cnt  output  CNT_W  redirect flushes taken, saturating

## Operation
- Load-use hazard (lu) = ex_memread && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
- FSM states are RUN and MEMWAIT. A 8-bit wait counter wcnt runs in MEMWAIT.
- Memory wait (mw) = mem_req && !mem_ack.
- RUN decisions, evaluated in priority order:
  - mw: pipe_freeze=1, pc_stall=1, ifid_stall=1; all other stall/flush outputs 0; next state MEMWAIT, wcnt<=1.
  - else redirect: ifid_flush=1, idex_flush=1; flush_cnt+1. lu is ignored because the instruction in ID is being squashed.
  - else lu: pc_stall=1, ifid_stall=1, idex_bubble=1, one cycle per detection. The next cycle re-evaluates lu with the bubble now in ID/EX, so it naturally clears.
  - else all outputs 0.
- MEMWAIT:
  - While !mem_ack and wcnt<MEM_TIMEOUT: same outputs as mw; wcnt+1. redirect and lu are ignored because EX and ID are frozen and stable.
  - mem_ack=1: freeze released this cycle; next state RUN; redirect and lu are evaluated exactly as in RUN this same cycle.
  - wcnt==MEM_TIMEOUT with no ack: mem_err=1 this cycle, freeze released, redirect/lu evaluated as in RUN, next state RUN, wcnt<=0.
- Counters: stall_cnt increments every cycle pc_stall=1. Both counters hold at 2^CNT_W-1 once reached.
- ex_rd==0 never causes a load-use stall.

## Timing
- All stall, flush, freeze and mem_err outputs are combinational from the current inputs and the registered state. They are valid in the same cycle as their cause, before the rising edge that must honour them.
- State, wcnt and the counters update on the rising clk edge.
- Reset (rst=0), asynchronous:
  - state=RUN, wcnt=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs are forced to 0 while rst=0.
- Reset mid-MEMWAIT returns to RUN immediately, with no mem_err pulse.
- Latencies:
  - Load-use costs exactly 1 stall cycle.
  - A redirect costs 2 squashed instructions with 0 extra cycles.
  - A memory wait of k cycles without ack costs k frozen cycles, then 1 release cycle.
- Simultaneous events: mw beats redirect, and redirect beats lu. redirect in the mem_ack release cycle is honoured in that cycle.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle, then ex_memread=0 -> pc_stall, ifid_stall and idex_bubble are 1 for exactly 1 cycle; stall_cnt=1.
- x0 and unused-operand cases: ex_rd=0 with a matching id_rs1; separately ex_rd=7, id_rs1=7, id_use_rs1=0 -> no stall.
- Redirect with lu also present: redirect=1 -> ifid_flush=idex_flush=1, idex_bubble=0, pc_stall=0; flush_cnt=1.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then ack -> pipe_freeze=1 for 3 cycles and 0 in the ack cycle; state returns to RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1 with no ack -> 4 frozen cycles, then mem_err=1 with freeze=0 on the 5th cycle, then RUN.
- Reset in MEMWAIT: drop rst during the 2nd wait cycle -> all outputs 0 immediately, counters 0, no mem_err; after release, normal RUN behaviour.
